// File: rtl/snax_tcdm_credit_port_if.sv
// Bus bundle for snax_tcdm_credit_port: upstream request/response pair plus the
// TCDM request (q) and response (p) channels. slave = the decoupler's view.
interface snax_tcdm_credit_port_if #(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned AddrWidth = 32
);
    localparam int unsigned StrbWidth = DataWidth / 8;

    logic                 req_valid;
    logic                 req_ready;
    logic [AddrWidth-1:0] req_addr;
    logic                 req_write;
    logic [StrbWidth-1:0] req_strb;
    logic [DataWidth-1:0] req_data;

    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [DataWidth-1:0] rsp_data;

    logic                 tcdm_q_valid;
    logic                 tcdm_q_ready;
    logic [AddrWidth-1:0] tcdm_q_addr;
    logic                 tcdm_q_write;
    logic [StrbWidth-1:0] tcdm_q_strb;
    logic [DataWidth-1:0] tcdm_q_data;

    logic                 tcdm_p_valid;
    logic [DataWidth-1:0] tcdm_p_data;

    modport slave (
        input  req_valid, req_addr, req_write, req_strb, req_data,
        output req_ready,
        output rsp_valid, rsp_data,
        input  rsp_ready,
        output tcdm_q_valid, tcdm_q_addr, tcdm_q_write, tcdm_q_strb, tcdm_q_data,
        input  tcdm_q_ready,
        input  tcdm_p_valid, tcdm_p_data
    );

    modport master (
        output req_valid, req_addr, req_write, req_strb, req_data,
        input  req_ready,
        input  rsp_valid, rsp_data,
        output rsp_ready,
        input  tcdm_q_valid, tcdm_q_addr, tcdm_q_write, tcdm_q_strb, tcdm_q_data,
        output tcdm_q_ready,
        output tcdm_p_valid, tcdm_p_data
    );
endinterface

// File: rtl/snax_tcdm_credit_port.sv
// Request register plus credit-limited response FIFO between one accelerator
// streamer port and one TCDM port; a read is only issued once FIFO space is reserved.
module snax_tcdm_credit_port #(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned Depth     = 4,
    parameter int unsigned CntWidth  = $clog2(Depth + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    snax_tcdm_credit_port_if.slave bus,
    output logic [CntWidth-1:0]   reserved_o,
    output logic                  idle_o,
    output logic                  err_o
);
    localparam int unsigned StrbWidth = DataWidth / 8;
    localparam int unsigned PtrWidth  = (Depth > 1) ? $clog2(Depth) : 1;
    localparam logic [CntWidth-1:0] DepthCnt = CntWidth'(Depth);
    localparam logic [PtrWidth-1:0] LastPtr  = PtrWidth'(Depth - 1);

    logic                 q_valid_reg;
    logic [AddrWidth-1:0] q_addr_reg;
    logic                 q_write_reg;
    logic [StrbWidth-1:0] q_strb_reg;
    logic [DataWidth-1:0] q_data_reg;

    logic [CntWidth-1:0]  reserved_reg, reserved_next;
    logic [CntWidth-1:0]  count_reg, count_next;
    logic [PtrWidth-1:0]  wr_ptr_reg, wr_ptr_next;
    logic [PtrWidth-1:0]  rd_ptr_reg, rd_ptr_next;
    logic                 err_reg, err_next;
    logic [DataWidth-1:0] mem_q [Depth];

    logic credit_avail;
    logic req_ready;
    logic req_fire;
    logic read_fire;
    logic fifo_full;
    logic fifo_empty;
    logic push;
    logic pop;
    logic overflow;

    function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] ptr);
        return (ptr == LastPtr) ? '0 : ptr + PtrWidth'(1);
    endfunction

    // Ready looks only at register state and the downstream ready, never at req_valid.
    assign credit_avail = (reserved_reg < DepthCnt);
    assign req_ready    = (!q_valid_reg || bus.tcdm_q_ready) && credit_avail;
    assign req_fire     = bus.req_valid && req_ready;
    assign read_fire    = req_fire && !bus.req_write;

    assign fifo_full  = (count_reg == DepthCnt);
    assign fifo_empty = (count_reg == '0);
    assign pop        = !fifo_empty && bus.rsp_ready;
    // A response into a full FIFO is dropped even if a pop happens in the same cycle.
    assign push       = bus.tcdm_p_valid && !fifo_full;
    assign overflow   = bus.tcdm_p_valid && fifo_full;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            q_valid_reg <= 1'b0;
            q_addr_reg  <= '0;
            q_write_reg <= 1'b0;
            q_strb_reg  <= '0;
            q_data_reg  <= '0;
        end else if (req_fire) begin
            q_valid_reg <= 1'b1;
            q_addr_reg  <= bus.req_addr;
            q_write_reg <= bus.req_write;
            q_strb_reg  <= bus.req_strb;
            q_data_reg  <= bus.req_data;
        end else if (bus.tcdm_q_ready) begin
            q_valid_reg <= 1'b0;
        end
    end

    always_comb begin
        reserved_next = reserved_reg;
        if (read_fire && !pop) begin
            reserved_next = reserved_reg + CntWidth'(1);
        end else if (pop && !read_fire && (reserved_reg != '0)) begin
            reserved_next = reserved_reg - CntWidth'(1);
        end
    end

    always_comb begin
        count_next  = count_reg;
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        err_next    = err_reg || overflow;
        if (push) begin
            wr_ptr_next = ptr_inc(wr_ptr_reg);
        end
        if (pop) begin
            rd_ptr_next = ptr_inc(rd_ptr_reg);
        end
        if (push && !pop) begin
            count_next = count_reg + CntWidth'(1);
        end else if (pop && !push) begin
            count_next = count_reg - CntWidth'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            reserved_reg <= '0;
            count_reg    <= '0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            err_reg      <= 1'b0;
        end else begin
            reserved_reg <= reserved_next;
            count_reg    <= count_next;
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            err_reg      <= err_next;
        end
    end

    // Storage is reset so the head reads as zero out of reset.
    for (genvar gi = 0; gi < Depth; gi++) begin : g_entry
        logic [DataWidth-1:0] entry_reg;
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                entry_reg <= '0;
            end else if (push && (wr_ptr_reg == PtrWidth'(gi))) begin
                entry_reg <= bus.tcdm_p_data;
            end
        end
        assign mem_q[gi] = entry_reg;
    end

    assign bus.req_ready    = req_ready;
    assign bus.tcdm_q_valid = q_valid_reg;
    assign bus.tcdm_q_addr  = q_addr_reg;
    assign bus.tcdm_q_write = q_write_reg;
    assign bus.tcdm_q_strb  = q_strb_reg;
    assign bus.tcdm_q_data  = q_data_reg;
    assign bus.rsp_valid    = !fifo_empty;
    assign bus.rsp_data     = mem_q[rd_ptr_reg];

    assign reserved_o = reserved_reg;
    assign idle_o     = !q_valid_reg && (reserved_reg == '0);
    assign err_o      = err_reg;
endmodule

// File: tb/tb_snax_tcdm_credit_port.sv
// Randomized bench for snax_tcdm_credit_port: a TCDM memory responder plus a
// queue-based reference of the request slot, credits and response FIFO.
`timescale 1ns/1ps
module tb_snax_tcdm_credit_port;
    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [CW-1:0] reserved;
    logic          idle;
    logic          err;

    snax_tcdm_credit_port_if #(.DataWidth(DW), .AddrWidth(AW)) bus ();

    snax_tcdm_credit_port #(.DataWidth(DW), .AddrWidth(AW), .Depth(DEPTH)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .bus        (bus),
        .reserved_o (reserved),
        .idle_o     (idle),
        .err_o      (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        int          due;
        logic [DW-1:0] data;
    } pend_t;

    logic [DW-1:0] tcdm_mem [64];
    logic [DW-1:0] gold_mem [64];
    pend_t         pend [$];
    logic [DW-1:0] m_fifo [$];
    logic [DW-1:0] gold_rd [$];

    bit            m_qv;
    logic [AW-1:0] m_addr;
    logic          m_write;
    logic [3:0]    m_strb;
    logic [DW-1:0] m_data;
    int            m_res;
    bit            m_err;

    int cyc = 0, last_due = -1;
    int k_valid, k_write, k_qready, k_rready, k_lat;
    int reqs_left = 0, seq_mode = 0, next_addr = 0, inject = 0;
    int dut_acc = 0, dut_pop = 0;
    bit            dir_en = 0;
    logic [AW-1:0] dir_addr;
    logic [DW-1:0] dir_data;
    logic [3:0]    dir_strb;

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                            input logic [3:0] s);
        logic [DW-1:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    task automatic set_knobs(input int v, input int w, input int qr, input int rr, input int lat);
        k_valid = v; k_write = w; k_qready = qr; k_rready = rr; k_lat = lat;
    endtask

    // One clock cycle: drive at negedge, check at negedge+1, advance the reference.
    task automatic tick();
        logic  exp_ready, acc, pop, hs, full_before;
        int    idx;
        pend_t pe;
        bus.req_valid = (reqs_left > 0) && ($urandom_range(99) < k_valid);
        if (dir_en) begin
            bus.req_write = 1'b1;
            bus.req_addr  = dir_addr;
            bus.req_strb  = dir_strb;
            bus.req_data  = dir_data;
        end else begin
            bus.req_write = ($urandom_range(99) < k_write);
            bus.req_addr  = seq_mode != 0 ? AW'(next_addr) : AW'($urandom_range(63) * 4);
            bus.req_strb  = 4'($urandom);
            bus.req_data  = $urandom;
        end
        bus.tcdm_q_ready = ($urandom_range(99) < k_qready);
        bus.rsp_ready    = ($urandom_range(99) < k_rready);
        if (inject != 0) begin
            bus.tcdm_p_valid = 1'b1;
            bus.tcdm_p_data  = 32'hBAD0_0BAD;
        end else if (pend.size() > 0 && pend[0].due == cyc) begin
            bus.tcdm_p_valid = 1'b1;
            bus.tcdm_p_data  = pend[0].data;
            void'(pend.pop_front());
        end else begin
            bus.tcdm_p_valid = 1'b0;
            bus.tcdm_p_data  = $urandom;
        end
        #1;
        exp_ready = (!m_qv || bus.tcdm_q_ready) && (m_res < DEPTH);
        check_eq("req_ready", bus.req_ready, exp_ready);
        check_eq("q_valid", bus.tcdm_q_valid, m_qv);
        if (m_qv) begin
            check_eq("q_addr", bus.tcdm_q_addr, m_addr);
            check_eq("q_write", bus.tcdm_q_write, m_write);
            check_eq("q_strb", bus.tcdm_q_strb, m_strb);
            check_eq("q_data", bus.tcdm_q_data, m_data);
        end
        check_eq("rsp_valid", bus.rsp_valid, m_fifo.size() != 0);
        if (m_fifo.size() != 0) check_eq("rsp_data", bus.rsp_data, m_fifo[0]);
        check_eq("reserved", reserved, m_res);
        check_eq("idle", idle, !m_qv && m_res == 0);
        check_eq("err", err, m_err);

        acc         = bus.req_valid && exp_ready;
        pop         = (m_fifo.size() != 0) && bus.rsp_ready;
        hs          = bus.tcdm_q_valid && bus.tcdm_q_ready;
        full_before = (m_fifo.size() == DEPTH);
        if (bus.req_valid && bus.req_ready) dut_acc++;
        if (bus.rsp_valid && bus.rsp_ready) dut_pop++;

        if (hs) begin
            idx = int'(bus.tcdm_q_addr[7:2]);
            if (bus.tcdm_q_write) begin
                tcdm_mem[idx] = merge(tcdm_mem[idx], bus.tcdm_q_data, bus.tcdm_q_strb);
            end else begin
                last_due = (cyc + k_lat > last_due + 1) ? cyc + k_lat : last_due + 1;
                pe.due   = last_due;
                pe.data  = tcdm_mem[idx];
                pend.push_back(pe);
            end
        end
        if (pop) begin
            if (gold_rd.size() > 0) begin
                check_eq("order", bus.rsp_data, gold_rd[0]);
                void'(gold_rd.pop_front());
            end
            void'(m_fifo.pop_front());
        end
        if (bus.tcdm_p_valid) begin
            if (full_before) m_err = 1'b1;
            else m_fifo.push_back(bus.tcdm_p_data);
        end
        if (acc) begin
            idx = int'(bus.req_addr[7:2]);
            if (bus.req_write) gold_mem[idx] = merge(gold_mem[idx], bus.req_data, bus.req_strb);
            else gold_rd.push_back(gold_mem[idx]);
            m_qv    = 1'b1;
            m_addr  = bus.req_addr;
            m_write = bus.req_write;
            m_strb  = bus.req_strb;
            m_data  = bus.req_data;
            if (reqs_left > 0) reqs_left--;
            next_addr += 4;
        end else if (bus.tcdm_q_ready) begin
            m_qv = 1'b0;
        end
        m_res = m_res + ((acc && !bus.req_write) ? 1 : 0) - (pop ? 1 : 0);
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    // Reset raised between clock edges so the checks observe its asynchronous effect.
    task automatic do_reset();
        bus.req_valid    = 1'b0;
        bus.rsp_ready    = 1'b0;
        bus.tcdm_q_ready = 1'b0;
        bus.tcdm_p_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check_eq("rst_q_valid", bus.tcdm_q_valid, 1'b0);
        check_eq("rst_rsp_valid", bus.rsp_valid, 1'b0);
        check_eq("rst_err", err, 1'b0);
        check_eq("rst_reserved", reserved, 0);
        check_eq("rst_idle", idle, 1'b1);
        check_eq("rst_q_addr", bus.tcdm_q_addr, 0);
        check_eq("rst_q_write", bus.tcdm_q_write, 1'b0);
        check_eq("rst_q_strb", bus.tcdm_q_strb, 0);
        check_eq("rst_q_data", bus.tcdm_q_data, 0);
        check_eq("rst_rsp_data", bus.rsp_data, 0);
        @(negedge clk);
        rst = 1'b0;
        m_qv = 1'b0; m_res = 0; m_err = 1'b0;
        m_fifo.delete(); gold_rd.delete(); pend.delete();
        last_due = -1;
        for (int i = 0; i < 64; i++) gold_mem[i] = tcdm_mem[i];
    endtask

    task automatic drain();
        int n;
        n = 0;
        reqs_left = 0;
        set_knobs(0, 0, 100, 100, 2);
        while ((m_fifo.size() > 0 || pend.size() > 0 || m_qv || m_res > 0) && n < 200) begin
            tick();
            n++;
        end
        check_eq("drain_idle", idle, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 64; i++) begin
            tcdm_mem[i] = 32'hA0 + i;
            gold_mem[i] = tcdm_mem[i];
        end
        bus.req_addr = '0; bus.req_write = 1'b0; bus.req_strb = '0; bus.req_data = '0;
        bus.tcdm_p_data = '0;
        set_knobs(0, 0, 100, 100, 2);
        do_reset();

        // Four back-to-back reads of 0x00..0x0C, responses 0xA0..0xA3.
        dut_pop = 0; seq_mode = 1; next_addr = 0; reqs_left = 4;
        set_knobs(100, 0, 100, 100, 2);
        repeat (10) tick();
        check_eq("t1_pops", dut_pop, 4);
        check_eq("t1_idle", idle, 1'b1);
        check_eq("t1_reserved", reserved, 0);
        seq_mode = 0;

        // Credit exhaustion with a stalled consumer, then a single pop.
        dut_acc = 0; reqs_left = 6;
        set_knobs(100, 0, 100, 0, 2);
        repeat (8) tick();
        check_eq("t2_accepted", dut_acc, 4);
        check_eq("t2_ready_low", bus.req_ready, 1'b0);
        k_rready = 100;
        tick();
        k_rready = 0;
        tick();
        check_eq("t2_accepted5", dut_acc, 5);
        drain();

        // Write held by a stalled TCDM for three cycles.
        dir_en = 1; dir_addr = 32'h40; dir_data = 32'hDEADBEEF; dir_strb = 4'hF; reqs_left = 1;
        set_knobs(100, 100, 0, 0, 2);
        repeat (4) tick();
        k_qready = 100;
        tick();
        dir_en = 0;
        check_eq("t3_mem", tcdm_mem[16], 32'hDEADBEEF);
        check_eq("t3_reserved", reserved, 0);

        // Mixed writes/reads with a random TCDM ready.
        reqs_left = 8;
        set_knobs(100, 50, 50, 100, 2);
        repeat (30) tick();
        drain();

        // Hold two entries, then stream with push and pop overlapping.
        reqs_left = 2;
        set_knobs(100, 0, 100, 0, 2);
        repeat (6) tick();
        reqs_left = 12;
        set_knobs(100, 0, 100, 100, 1);
        repeat (20) tick();
        drain();

        for (int p = 0; p < 12; p++) begin
            reqs_left = 1000;
            set_knobs(int'($urandom_range(30, 100)), int'($urandom_range(0, 60)),
                      int'($urandom_range(20, 100)), int'($urandom_range(10, 100)),
                      int'($urandom_range(1, 4)));
            repeat (150) tick();
            drain();
        end

        // Overflow: fill the FIFO, inject an unsolicited response.
        reqs_left = 4;
        set_knobs(100, 0, 100, 0, 2);
        repeat (8) tick();
        check_eq("e_full_reserved", reserved, DEPTH);
        inject = 1;
        tick();
        inject = 0;
        repeat (3) tick();
        check_eq("e_sticky", err, 1'b1);
        drain();
        check_eq("e_after_drain", err, 1'b1);
        do_reset();
        repeat (2) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
